// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the divider slice: datapath width and divider FSM states.
package cpu_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ITER,
        FIX,
        DZ
    } div_state_t;

endpackage : cpu_pkg

// File: rtl/div_unit_if.sv
// Handshake and operand/result bundle between control_unit/datapath and the divider.
interface div_unit_if
    import cpu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic                    div_start;
    logic signed [WIDTH-1:0] dividend;
    logic signed [WIDTH-1:0] divisor;
    logic        [WIDTH-1:0] hi_out;
    logic        [WIDTH-1:0] lo_out;
    logic                    div_busy;
    logic                    div_done;
    logic                    divzero;

    // master = requester (control unit / datapath), slave = the divider
    modport master (
        output div_start, dividend, divisor,
        input  hi_out, lo_out, div_busy, div_done, divzero
    );

    modport slave (
        input  div_start, dividend, divisor,
        output hi_out, lo_out, div_busy, div_done, divzero
    );

endinterface : div_unit_if

// File: rtl/div_unit_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the remainder, subtract if it fits.
module div_step
    import cpu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] trial;
    logic           fits;

    // Compare at WIDTH+1 bits so a divisor magnitude of 2^(WIDTH-1) never overflows.
    assign trial = {rem_i, q_i[WIDTH-1]};
    assign fits  = (trial >= {1'b0, d_i});

    always_comb begin
        rem_o = trial[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b0};
        if (fits) begin
            rem_o = trial[WIDTH-1:0] - d_i;
            q_o   = {q_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule : div_step

// File: rtl/div_unit.sv
// Multicycle signed divider (MIPS div semantics) producing quotient on lo_out and remainder on hi_out.
module div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic       clk,
    input  logic       reset,
    div_unit_if.slave  bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    div_state_t              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [WIDTH-1:0] a_q, a_d;
    logic signed [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0]        rem_q, rem_d;
    logic [WIDTH-1:0]        quo_q, quo_d;
    logic [WIDTH-1:0]        dvs_q, dvs_d;
    logic                    qsign_q, qsign_d;
    logic                    rsign_q, rsign_d;
    logic [WIDTH-1:0]        hi_q, hi_d;
    logic [WIDTH-1:0]        lo_q, lo_d;
    logic                    done_q, done_d;
    logic                    dz_q, dz_d;
    logic [WIDTH-1:0]        step_rem, step_quo;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (WIDTH'(0) - v) : v;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .q_i   (quo_q),
        .d_i   (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_quo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.div_start) begin
                    if (bus.divisor != '0) begin
                        a_d     = bus.dividend;
                        b_d     = bus.divisor;
                        state_d = SETUP;
                    end else begin
                        state_d = DZ;
                    end
                end
            end
            SETUP: begin
                // Magnitudes as unsigned: |most-negative| becomes 2^(WIDTH-1), which fits.
                quo_d   = cond_neg(a_q, a_q[WIDTH-1]);
                dvs_d   = cond_neg(b_q, b_q[WIDTH-1]);
                rem_d   = '0;
                qsign_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
                rsign_d = a_q[WIDTH-1];
                cnt_d   = '0;
                state_d = ITER;
            end
            ITER: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                lo_d    = cond_neg(quo_q, qsign_q);
                hi_d    = cond_neg(rem_q, rsign_q);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            DZ: begin
                dz_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;
    assign bus.div_done = done_q;
    assign bus.divzero  = dz_q;
    assign bus.div_busy = (state_q == SETUP) || (state_q == ITER) || (state_q == FIX);

endmodule : div_unit

// File: tb/tb_div_unit.sv
// Directed, table-driven bench for div_unit: result values, latency, pulse shape, and multi-cycle corners.
module tb_div_unit;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request and watch 40 edges after the sampling edge E0.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] lo, output logic [31:0] hi,
                           output int lat, output logic dzf, output int pulses,
                           output logic both, output logic busy1, output logic busy_post);
        lat = 0; dzf = 1'b0; pulses = 0; both = 1'b0; busy1 = 1'b0; busy_post = 1'b1;
        lo = '0; hi = '0;
        @(negedge clk);
        bus.div_start = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clk);
        @(negedge clk);
        bus.div_start = 1'b0;
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) busy1 = bus.div_busy;
            if (bus.div_done && bus.divzero) both = 1'b1;
            if (bus.div_done || bus.divzero) begin
                pulses++;
                if (lat == 0) begin
                    lat = i;
                    dzf = bus.divzero;
                    lo  = bus.lo_out;
                    hi  = bus.hi_out;
                end
            end
            if (lat != 0 && i == lat + 1) busy_post = bus.div_busy;
        end
    endtask

    initial begin
        logic [31:0] lo, hi, exp_lo, exp_hi;
        int          lat, pulses;
        logic        dzf, both, busy1, busy_post;

        n_cmp = 0;
        n_err = 0;
        bus.div_start = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        rst_n = 1'b0;

        vecs[0]  = '{32'd7,        32'd2,        32'd3,        32'd1,        1'b0};
        vecs[1]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
        vecs[2]  = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
        vecs[3]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0};
        vecs[4]  = '{32'h00000451, 32'h00000020, 32'h00000022, 32'h00000011, 1'b0};
        vecs[5]  = '{32'd5,        32'd0,        32'h00000022, 32'h00000011, 1'b1};
        vecs[6]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
        vecs[7]  = '{32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b0};
        vecs[8]  = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0};
        vecs[9]  = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0,        1'b0};
        vecs[10] = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
        vecs[11] = '{32'hFFFFFFFF, 32'h80000000, 32'd0,        32'hFFFFFFFF, 1'b0};
        vecs[12] = '{32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_lo",   bus.lo_out, 32'd0);
        chk("reset_hi",   bus.hi_out, 32'd0);
        chk("reset_busy", {31'd0, bus.div_busy}, 32'd0);
        chk("reset_done", {31'd0, bus.div_done}, 32'd0);
        chk("reset_dz",   {31'd0, bus.divzero},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < NV; v++) begin
            run_div(vecs[v].a, vecs[v].b, lo, hi, lat, dzf, pulses, both, busy1, busy_post);
            chk($sformatf("v%0d_latency", v), lat, vecs[v].dz ? 32'd1 : 32'd34);
            chk($sformatf("v%0d_lo", v), lo, vecs[v].lo);
            chk($sformatf("v%0d_hi", v), hi, vecs[v].hi);
            chk($sformatf("v%0d_kind", v), {31'd0, dzf}, {31'd0, vecs[v].dz});
            chk($sformatf("v%0d_pulses", v), pulses, 32'd1);
            chk($sformatf("v%0d_overlap", v), {31'd0, both}, 32'd0);
            chk($sformatf("v%0d_busy_e1", v), {31'd0, busy1}, {31'd0, ~vecs[v].dz});
            chk($sformatf("v%0d_busy_after", v), {31'd0, busy_post}, 32'd0);
        end

        // Reset in the middle of an operation, then a normal run.
        @(negedge clk);
        bus.div_start = 1'b1;
        bus.dividend  = 32'd100;
        bus.divisor   = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.div_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("midrst_busy_before", {31'd0, bus.div_busy}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_lo",   bus.lo_out, 32'd0);
        chk("midrst_hi",   bus.hi_out, 32'd0);
        chk("midrst_busy", {31'd0, bus.div_busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.div_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_div(32'd100, 32'd7, lo, hi, lat, dzf, pulses, both, busy1, busy_post);
        chk("postrst_latency", lat, 32'd34);
        chk("postrst_lo", lo, 32'd14);
        chk("postrst_hi", hi, 32'd2);
        chk("postrst_pulses", pulses, 32'd1);

        // A second start while busy must be ignored.
        exp_lo = 32'd3;
        exp_hi = 32'd0;
        lat = 0; pulses = 0;
        @(negedge clk);
        bus.div_start = 1'b1;
        bus.dividend  = 32'd9;
        bus.divisor   = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.div_start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.div_done) begin
                pulses++;
                if (lat == 0) begin
                    lat = i;
                    lo  = bus.lo_out;
                    hi  = bus.hi_out;
                end
            end
            if (i == 4) begin
                @(negedge clk);
                bus.div_start = 1'b1;
                bus.dividend  = 32'd50;
                bus.divisor   = 32'd5;
            end else if (i == 5) begin
                @(negedge clk);
                bus.div_start = 1'b0;
            end
        end
        chk("ignore_latency", lat, 32'd34);
        chk("ignore_lo", lo, exp_lo);
        chk("ignore_hi", hi, exp_hi);
        chk("ignore_pulses", pulses, 32'd1);
        chk("ignore_idle_end", {31'd0, bus.div_busy}, 32'd0);
        chk("ignore_hold_lo", bus.lo_out, exp_lo);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule : tb_div_unit
